// File: rtl/misty_arbiter.sv
// Two-requester round-robin arbiter in front of one shared MISTY core.
// Optional WAIT watchdog enabled by defining MISTY_ARB_WATCHDOG_EN.
module misty_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid_i,
  output logic [1:0]   req_ready_o,
  input  logic         req0_enc_i,
  input  logic         req1_enc_i,
  input  logic [63:0]  req0_text_i,
  input  logic [63:0]  req1_text_i,
  input  logic [255:0] req0_key_i,
  input  logic [255:0] req1_key_i,
  output logic         core_valid_o,
  input  logic         core_ready_i,
  output logic         core_enc_o,
  output logic [63:0]  core_text_o,
  output logic [255:0] core_key_o,
  output logic         core_stall_o,
  input  logic         core_valid_i,
  input  logic [63:0]  core_text_i,
  output logic [1:0]   resp_valid_o,
  input  logic [1:0]   resp_ready_i,
  output logic [63:0]  resp_text_o,
  output logic         resp_err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t         state_q, state_d;
  logic           ptr_q, ptr_d;
  logic           owner_q, owner_d;
  logic           enc_q, enc_d;
  logic [63:0]    text_q, text_d;
  logic [255:0]   key_q, key_d;
  logic [63:0]    result_q, result_d;
  logic           grant_id;
  logic           wd_expired;

`ifdef MISTY_ARB_WATCHDOG_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]  wd_cnt_q, wd_cnt_d;
  logic           err_q, err_d;

  // Counter holds the number of WAIT cycles already elapsed, so the limit is
  // reached at the end of the cycle where it equals TIMEOUT_CYCLES-1.
  assign wd_expired = (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expired = 1'b0;
`endif

  // Pointer only matters when both requesters compete.
  assign grant_id = (req_valid_i == 2'b11) ? ptr_q : req_valid_i[1];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    enc_d    = enc_q;
    text_d   = text_q;
    key_d    = key_q;
    result_d = result_q;
`ifdef MISTY_ARB_WATCHDOG_EN
    wd_cnt_d = wd_cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          owner_d = grant_id;
          enc_d   = grant_id ? req1_enc_i  : req0_enc_i;
          text_d  = grant_id ? req1_text_i : req0_text_i;
          key_d   = grant_id ? req1_key_i  : req0_key_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (core_ready_i) begin
          state_d = WAIT;
`ifdef MISTY_ARB_WATCHDOG_EN
          wd_cnt_d = '0;
`endif
        end
      end
      WAIT: begin
        if (core_valid_i) begin
          result_d = core_text_i;
          state_d  = HOLD;
        end else if (wd_expired) begin
          result_d = '0;
          state_d  = HOLD;
`ifdef MISTY_ARB_WATCHDOG_EN
          err_d    = 1'b1;
`endif
        end else begin
`ifdef MISTY_ARB_WATCHDOG_EN
          wd_cnt_d = wd_cnt_q + CW'(1);
`endif
        end
      end
      HOLD: begin
        if (resp_ready_i[owner_q]) begin
          state_d = IDLE;
          ptr_d   = ~owner_q;
`ifdef MISTY_ARB_WATCHDOG_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      enc_q    <= 1'b0;
      text_q   <= '0;
      key_q    <= '0;
      result_q <= '0;
`ifdef MISTY_ARB_WATCHDOG_EN
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      enc_q    <= enc_d;
      text_q   <= text_d;
      key_q    <= key_d;
      result_q <= result_d;
`ifdef MISTY_ARB_WATCHDOG_EN
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Outputs are forced low while rst is high, even before the first edge.
  assign req_ready_o  = (!rst && state_q == IDLE && |req_valid_i) ?
                        (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign core_valid_o = !rst && (state_q == ISSUE);
  assign core_enc_o   = !rst && enc_q;
  assign core_text_o  = rst ? '0 : text_q;
  assign core_key_o   = rst ? '0 : key_q;
  assign core_stall_o = !rst && (state_q == HOLD);
  assign resp_valid_o = (!rst && state_q == HOLD) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign resp_text_o  = rst ? '0 : result_q;
`ifdef MISTY_ARB_WATCHDOG_EN
  assign resp_err_o   = !rst && err_q;
`else
  assign resp_err_o   = 1'b0;
`endif

endmodule
